// File: rtl/pdm_cic_dec.sv
// pdm_cic_dec: third-order CIC decimator turning a 1-bit PDM stream into signed PCM samples.
// Integrators wrap freely at W bits; the combs cancel the wrap exactly.
module pdm_cic_dec #(
    parameter int DEC_LOG2 = 6,
    parameter int OW       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pdm_ena,
    input  logic                 pdm_in,
    output logic signed [OW-1:0] pcm_out,
    output logic                 pcm_valid
);
    localparam int W  = 3*DEC_LOG2 + 2;
    localparam int SH = 3*DEC_LOG2 - (OW-1);
    localparam logic signed [W-1:0] PMAX = W'(2**(OW-1) - 1);
    localparam logic signed [W-1:0] NMIN = ~PMAX;

    logic signed [W-1:0] x, i1, i2, i3, i1_n, i2_n, i3_n;
    logic signed [W-1:0] s0_prev, c1, c1_prev, c2, c2_prev, c3, y;
    logic signed [OW-1:0] pcm_n;
    logic [DEC_LOG2-1:0] cnt;
    logic dec_stb, v1, v2, v3;

    always_comb begin
        x     = pdm_in ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
        i1_n  = i1 + x;
        i2_n  = i2 + i1_n;
        i3_n  = i3 + i2_n;
        y     = c3 >>> SH;
        pcm_n = y > PMAX ? PMAX[OW-1:0] : y < NMIN ? NMIN[OW-1:0] : y[OW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i1 <= '0;
            i2 <= '0;
            i3 <= '0;
            cnt <= '0;
            dec_stb <= 1'b0;
        end else begin
            dec_stb <= pdm_ena && cnt == '1;
            if (pdm_ena) begin
                i1 <= i1_n;
                i2 <= i2_n;
                i3 <= i3_n;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Stage 0 is the integrator value itself; only its prev copy is stored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_prev <= '0;
            c1 <= '0;
            c1_prev <= '0;
            c2 <= '0;
            c2_prev <= '0;
            c3 <= '0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            pcm_out <= '0;
            pcm_valid <= 1'b0;
        end else begin
            v1 <= dec_stb;
            v2 <= v1;
            v3 <= v2;
            pcm_valid <= v3;
            if (dec_stb) begin
                c1 <= i3 - s0_prev;
                s0_prev <= i3;
            end
            if (v1) begin
                c2 <= c1 - c1_prev;
                c1_prev <= c1;
            end
            if (v2) begin
                c3 <= c2 - c2_prev;
                c2_prev <= c2;
            end
            if (v3) pcm_out <= pcm_n;
        end
    end
endmodule

// File: tb/tb_pdm_cic_dec.sv
// tb_pdm_cic_dec: directed PDM patterns; expected samples and their arrival cycles are queued
// by the stimulus and checked by an independent monitor on each pcm_valid.
module tb_pdm_cic_dec;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pdm_ena = 1'b0;
    logic pdm_in = 1'b0;
    logic signed [15:0] pcm_out;
    logic pcm_valid;

    typedef struct {
        int     val;
        bit     chk;
        longint cyc;
    } exp_t;

    exp_t q[$];
    longint cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int scnt = 0;
    int samp = 0;

    pdm_cic_dec #(.DEC_LOG2(6), .OW(16)) dut (
        .clk(clk), .reset(reset), .pdm_ena(pdm_ena), .pdm_in(pdm_in),
        .pcm_out(pcm_out), .pcm_valid(pcm_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && pcm_valid) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid at cycle %0d pcm_out=%0d", cyc, pcm_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL valid_timing sample %0d: got cycle %0d, required %0d", samp, cyc, e.cyc);
                end
                if (e.chk) begin
                    n_cmp++;
                    if (pcm_out !== e.val) begin
                        n_bad++;
                        $display("FAIL pcm_value at cycle %0d: got %0d, required %0d", cyc, pcm_out, e.val);
                    end
                end
            end
        end
    end

    // Strobes follow pattern bits in order pat[0], pat[1], ...; every 64th strobe queues a sample.
    task automatic drive(input logic [3:0] pat, input int plen, input int period,
                         input int nstr, input int exp_v);
        int k = 0;
        int p = 0;
        int s = 0;
        while (s < nstr) begin
            @(posedge clk);
            #1;
            if (k % period == 0) begin
                pdm_ena = 1'b1;
                pdm_in = pat[p];
                p = (p + 1) % plen;
                s++;
                scnt++;
                if (scnt % 64 == 0) begin
                    samp++;
                    q.push_back('{val: exp_v, chk: samp >= 4, cyc: cyc + 5});
                end
            end else begin
                pdm_ena = 1'b0;
            end
            k++;
        end
        @(posedge clk);
        #1;
        pdm_ena = 1'b0;
    endtask

    task automatic do_reset(input bit drain);
        if (drain) repeat (8) @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_samples: %0d pending, required 0", q.size());
            q.delete();
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (pcm_out !== 16'sd0 || pcm_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: pcm_out=%0d pcm_valid=%b, required 0/0", pcm_out, pcm_valid);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        scnt = 0;
        samp = 0;
    endtask

    initial begin
        do_reset(1'b0);
        drive(4'b0001, 1, 1, 8*64, 32767);
        do_reset(1'b1);
        drive(4'b0000, 1, 1, 7*64, -32768);
        do_reset(1'b1);
        drive(4'b0001, 2, 1, 7*64, 0);
        do_reset(1'b1);
        drive(4'b0111, 4, 1, 7*64, 16384);
        do_reset(1'b1);
        drive(4'b0111, 4, 3, 6*64, 16384);
        do_reset(1'b1);
        drive(4'b0111, 4, 1, 6*64 + 30, 16384);
        do_reset(1'b0);
        drive(4'b0001, 1, 1, 6*64, 32767);
        repeat (10) @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_samples_at_end: %0d pending, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pdm_cic_dec.md
# pdm_cic_dec

Third-order CIC decimator that recovers multi-bit PCM samples from a 1-bit sigma-delta (PDM) bitstream. It is the receive-side counterpart of the PDM DAC modulator in the ADC design. It gives us a loopback path: PDM_L/PDM_R are decoded back to PCM and compared against the source samples, on the bench and on hardware. It also gives us an input path for external PDM sources such as MEMS microphones. One instance handles one channel; stereo uses two instances.

## Interface
- DEC_LOG2, default 6: log2 of the decimation ratio R. R = 2^DEC_LOG2, legal range 3..10.
- OW, default 16: PCM output width. Requires 3*DEC_LOG2 >= OW-1.
- clk, input, 1: system clock. Single clock domain.
- reset, input, 1: asynchronous, active-high reset.
- pdm_ena, input, 1: bit-rate strobe. pdm_in is consumed in cycles where pdm_ena=1.
- pdm_in, input, 1: PDM bit, synchronous to clk. 1 means +1, 0 means -1.
- pcm_out, output, OW: signed PCM sample, held between updates.
- pcm_valid, output, 1: one-cycle pulse marking a new pcm_out.

## Operation
- Internal width W = 3*DEC_LOG2 + 2 bits, two's complement, for all integrators and combs.
- Integrators:
  - x = +1 when pdm_in=1, -1 when pdm_in=0, sign-extended to W.
  - On each pdm_ena cycle: i1 += x; i2 += i1(new); i3 += i2(new).
  - All three are registered and update on the same edge.
  - Overflow wraps modulo 2^W. No saturation inside the filter; the combs cancel the wrap exactly.
  - Integrators hold when pdm_ena=0.
- Decimation counter:
  - DEC_LOG2 bits, increments on each pdm_ena and wraps R-1 -> 0.
  - The pdm_ena cycle in which the counter is R-1 is the decimation cycle N.
  - At the end of N, dec_stb is registered high for one cycle.
- Comb pipeline, advancing only on dec_stb and the stages that follow it:
  - Stage 0 latches s0 = i3.
  - c1 = s0 - s0_prev.
  - c2 = c1 - c1_prev.
  - c3 = c2 - c2_prev.
  - Each stage is one registered clock. Each "prev" register updates only when its own stage fires.
- Output scaling:
  - y = c3 >>> (3*DEC_LOG2 - (OW-1)), arithmetic shift.
  - Saturate to [-2^(OW-1), 2^(OW-1)-1].
  - Full-scale positive input gives c3 = +R^3 and pcm_out = 2^(OW-1)-1.
  - Full-scale negative input gives -R^3 and -2^(OW-1).
- Start-up: the first 3 valid samples after reset are transient. The 4th and later samples are exact steady-state values.
- Reset, asynchronous, effective any time including mid-frame:
  - Clears all integrators, combs, prev registers, counter, dec_stb, the pipeline flags, pcm_out=0 and pcm_valid=0.
  - A frame in progress is discarded.
  - After release, the first decimation occurs on the R-th pdm_ena.

## Timing
- pdm_ena may be asserted every cycle or with any gap pattern. The output rate is one sample per R strobes.
- Latency, for the decimation cycle N:
  - The integrators update at the edge ending N.
  - dec_stb is high in N+1.
  - c1, c2 and c3 are registered at the edges ending N+1, N+2 and N+3.
  - pcm_out is registered at the edge ending N+4.
  - pcm_valid is high in cycle N+5 for exactly one cycle.
- Since R >= 8, the pipeline always completes before the next decimation. No backpressure is required.
- pcm_out changes only on the edge that raises pcm_valid.
- pdm_ena in cycles N+1..N+4 is legal and integrates normally. The pipeline uses only the values latched at stage 0.

## Test plan
- All-ones pdm_in, pdm_ena=1 every cycle, defaults:
  - from the 4th pcm_valid onward pcm_out = 32767;
  - pcm_valid spacing is exactly 64 clocks.
- All-zeros input: steady-state pcm_out = -32768.
- Alternating 1,0 pattern: steady-state pcm_out = 0. Pattern 1,1,1,0 repeating: steady-state pcm_out = 16384.
- pdm_ena once every 3 clocks with the 1,1,1,0 pattern:
  - values are identical (16384);
  - pcm_valid spacing is 192 clocks;
  - pcm_valid rises 5 clocks after the 64th strobe cycle.
- Reset asserted asynchronously when the counter is 30:
  - pcm_out=0 and pcm_valid=0 immediately;
  - after release, the first pcm_valid comes 5 clocks after the 64th subsequent strobe.
- Loopback: run 10^6 cycles, long enough for the integrators to wrap.
  - Drive a 1.441 MHz-scaled sine of amplitude 100 (10-bit) through the PDM modulator into this block.
  - The decoded sine matches the source within ±1% amplitude after gain normalization.
  - No glitches appear at integrator wrap points.
